// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: VOICES x V_OSC phase accumulators serviced one slot
// per cycle, with per-voice hard sync, per-oscillator phase offset and waveform shaping.
module osc_bank #(
   parameter int unsigned VOICES  = 8,
   parameter int unsigned V_OSC   = 4,
   parameter int unsigned V_WIDTH = 3,
   parameter int unsigned O_WIDTH = 2,
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned N       = VOICES * V_OSC
) (
   input  logic                      sCLK_XVXOSC,
   input  logic                      reset_reg,
   input  logic                      run,
   output logic [V_WIDTH-1:0]        slot_vx,
   output logic [O_WIDTH-1:0]        slot_ox,
   output logic                      slot_issue,
   input  logic [PHASE_W-1:0]        osc_pitch_val,
   input  logic signed [ADDR_W-1:0]  modulation,
   input  logic [VOICES-1:0]         sync_req,
   input  logic                      reg_write,
   input  logic                      reg_read,
   input  logic                      osc_sel,
   input  logic [6:0]                reg_adr,
   input  logic [7:0]                reg_wdata,
   output logic [7:0]                reg_rdata,
   output logic                      reg_rvalid,
   output logic                      busy,
   output logic                      out_valid,
   output logic [V_WIDTH-1:0]        out_vx,
   output logic [O_WIDTH-1:0]        out_ox,
   output logic [ADDR_W-1:0]         lut_addr,
   output logic signed [ADDR_W-1:0]  wave_out,
   output logic                      wave_is_sine
);

   localparam int unsigned S_W = V_WIDTH + O_WIDTH;
   localparam logic [S_W-1:0] LAST_SLOT = S_W'(N - 1);

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RUN} state_t;

   state_t              state, state_d;
   logic                busy_d, issue_d, clr_we;
   logic [S_W-1:0]      clr_cnt, slot_cnt;
   logic [PHASE_W-1:0]  acc [N];
   logic [N-1:0]        pend, pend_set, pend_clr;
   logic [7:0]          offs [V_OSC];
   logic [1:0]          mode [V_OSC];

   logic                p1_valid, p2_valid;
   logic [S_W-1:0]      p1_slot, p2_slot;
   logic [ADDR_W-1:0]   p2_top;
   logic [PHASE_W-1:0]  acc_nxt;

   // FSM state register, with busy/slot_issue registered from the next state
   always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
      if (reset_reg) begin
         state      <= ST_CLEAR;
         busy       <= 1'b1;
         slot_issue <= 1'b0;
      end else begin
         state      <= state_d;
         busy       <= busy_d;
         slot_issue <= issue_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_CLEAR: if (clr_cnt == LAST_SLOT) state_d = run ? ST_RUN : ST_IDLE;
         ST_IDLE,
         ST_RUN:   state_d = run ? ST_RUN : ST_IDLE;
         default:  state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy_d  = (state_d == ST_CLEAR);
      issue_d = (state_d == ST_RUN);
      clr_we  = (state == ST_CLEAR);
   end

   // Clear sweep pointer and slot sequencer
   always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
      if (reset_reg) begin
         clr_cnt  <= '0;
         slot_cnt <= '0;
      end else begin
         if (clr_we) clr_cnt <= (clr_cnt == LAST_SLOT) ? '0 : clr_cnt + S_W'(1);
         if (slot_issue) slot_cnt <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + S_W'(1);
      end
   end

   assign slot_vx = slot_cnt[S_W-1 -: V_WIDTH];
   assign slot_ox = slot_cnt[O_WIDTH-1:0];

   // Hard-sync pending flags; a new pulse wins over the clear of the slot being processed
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      for (int unsigned v = 0; v < VOICES; v++)
         pend_set[v*V_OSC +: V_OSC] = {V_OSC{sync_req[v]}};
      if (p1_valid) pend_clr[p1_slot] = 1'b1;
   end

   assign acc_nxt = pend[p1_slot] ? osc_pitch_val : acc[p1_slot] + osc_pitch_val;

   always_ff @(posedge sCLK_XVXOSC) begin
      if (clr_we)        acc[clr_cnt] <= '0;
      else if (p1_valid) acc[p1_slot] <= acc_nxt;
   end

   always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
      if (reset_reg) begin
         pend     <= '0;
         p1_valid <= 1'b0;
         p1_slot  <= '0;
         p2_valid <= 1'b0;
         p2_slot  <= '0;
         p2_top   <= '0;
      end else begin
         pend     <= (pend & ~pend_clr) | pend_set;
         p1_valid <= slot_issue;
         p1_slot  <= slot_cnt;
         p2_valid <= p1_valid;
         p2_slot  <= p1_slot;
         p2_top   <= acc_nxt[PHASE_W-1 -: ADDR_W];
      end
   end

   // Address and waveform shaping for the slot in stage 2
   logic [O_WIDTH-1:0] p2_ox;
   logic [ADDR_W-1:0]  offs_ext, offs_sh, addr, wave_d, tri_sh;
   logic [ADDR_W-2:0]  tri_fold;
   logic               sine_d;

   always_comb begin
      p2_ox    = p2_slot[O_WIDTH-1:0];
      offs_ext = ADDR_W'({{(ADDR_W-8){offs[p2_ox][7]}}, offs[p2_ox]});
      offs_sh  = offs_ext << 3;
      addr     = p2_top + $unsigned(modulation) + offs_sh;
      tri_fold = addr[ADDR_W-1] ? ~addr[ADDR_W-2:0] : addr[ADDR_W-2:0];
      tri_sh   = {tri_fold, 1'b0};
      wave_d   = '0;
      sine_d   = 1'b0;
      case (mode[p2_ox])
         2'd0:    sine_d = 1'b1;
         2'd1:    wave_d = {~addr[ADDR_W-1], addr[ADDR_W-2:0]};
         2'd2:    wave_d = addr[ADDR_W-1] ? {1'b0, {(ADDR_W-1){1'b1}}} : {1'b1, {(ADDR_W-1){1'b0}}};
         default: wave_d = {~tri_sh[ADDR_W-1], tri_sh[ADDR_W-2:0]};
      endcase
   end

   always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
      if (reset_reg) begin
         out_valid    <= 1'b0;
         out_vx       <= '0;
         out_ox       <= '0;
         lut_addr     <= '0;
         wave_out     <= '0;
         wave_is_sine <= 1'b0;
      end else begin
         out_valid <= p2_valid;
         if (p2_valid) begin
            out_vx       <= p2_slot[S_W-1 -: V_WIDTH];
            out_ox       <= p2_ox;
            lut_addr     <= addr;
            wave_out     <= wave_d;
            wave_is_sine <= sine_d;
         end
      end
   end

   // Register file: offs at 6+16*o, mode at 7+16*o
   logic [2:0]         reg_o;
   logic [O_WIDTH-1:0] reg_oi;
   logic               is_offs, is_mode;
   logic [7:0]         rd_d;

   always_comb begin
      reg_o   = reg_adr[6:4];
      reg_oi  = reg_adr[4 +: O_WIDTH];
      is_offs = (32'(reg_o) < V_OSC) && (reg_adr[3:0] == 4'd6);
      is_mode = (32'(reg_o) < V_OSC) && (reg_adr[3:0] == 4'd7);
      rd_d    = 8'h00;
      if (is_offs)      rd_d = offs[reg_oi];
      else if (is_mode) rd_d = {6'b0, mode[reg_oi]};
   end

   always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
      if (reset_reg) begin
         for (int unsigned i = 0; i < V_OSC; i++) begin
            offs[i] <= '0;
            mode[i] <= '0;
         end
         reg_rdata  <= '0;
         reg_rvalid <= 1'b0;
      end else begin
         if (reg_write && osc_sel) begin
            if (is_offs) offs[reg_oi] <= reg_wdata;
            if (is_mode) mode[reg_oi] <= reg_wdata[1:0];
         end
         reg_rvalid <= reg_read && osc_sel;
         if (reg_read && osc_sel) reg_rdata <= rd_d;
      end
   end

endmodule

// File: tb/tb_osc_bank.sv
// Directed self-checking bench for osc_bank: clear sweep, phase accumulation, registers,
// hard sync, wrap-around, waveform modes, drain and mid-run reset.
module tb_osc_bank;

   logic               sCLK_XVXOSC = 1'b0;
   logic               reset_reg, run;
   logic [2:0]         slot_vx;
   logic [1:0]         slot_ox;
   logic               slot_issue;
   logic [23:0]        osc_pitch_val;
   logic signed [10:0] modulation;
   logic [7:0]         sync_req;
   logic               reg_write, reg_read, osc_sel;
   logic [6:0]         reg_adr;
   logic [7:0]         reg_wdata, reg_rdata;
   logic               reg_rvalid, busy, out_valid;
   logic [2:0]         out_vx;
   logic [1:0]         out_ox;
   logic [10:0]        lut_addr;
   logic signed [10:0] wave_out;
   logic               wave_is_sine;

   int tests = 0;
   int fails = 0;

   osc_bank dut (
      .sCLK_XVXOSC(sCLK_XVXOSC), .reset_reg(reset_reg), .run(run),
      .slot_vx(slot_vx), .slot_ox(slot_ox), .slot_issue(slot_issue),
      .osc_pitch_val(osc_pitch_val), .modulation(modulation), .sync_req(sync_req),
      .reg_write(reg_write), .reg_read(reg_read), .osc_sel(osc_sel),
      .reg_adr(reg_adr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_rvalid(reg_rvalid), .busy(busy), .out_valid(out_valid),
      .out_vx(out_vx), .out_ox(out_ox), .lut_addr(lut_addr),
      .wave_out(wave_out), .wave_is_sine(wave_is_sine)
   );

   always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

   task automatic tick();
      @(negedge sCLK_XVXOSC);
   endtask

   task automatic wait_out(input logic [2:0] vx, input logic [1:0] ox, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (out_valid === 1'b1 && out_vx === vx && out_ox === ox) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_issue(input logic [2:0] vx, input logic [1:0] ox, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (slot_issue === 1'b1 && slot_vx === vx && slot_ox === ox) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic reg_wr(input logic [6:0] a, input logic [7:0] d, input logic sel);
      reg_write = 1'b1; osc_sel = sel; reg_adr = a; reg_wdata = d;
      tick();
      reg_write = 1'b0; osc_sel = 1'b0;
   endtask

   task automatic reg_rd(input logic [6:0] a);
      reg_read = 1'b1; osc_sel = 1'b1; reg_adr = a;
      tick();
      reg_read = 1'b0; osc_sel = 1'b0;
   endtask

   task automatic test_reset();
      tests++;
      if ({busy, slot_issue, out_valid, reg_rvalid} !== 4'b1000) begin
         fails++; $display("FAIL reset_ctrl: got %b want 1000", {busy, slot_issue, out_valid, reg_rvalid});
      end
      tests++;
      if ({reg_rdata, lut_addr, wave_out, wave_is_sine, out_vx, out_ox, slot_vx, slot_ox} !== 45'd0) begin
         fails++; $display("FAIL reset_data: got %h want 0",
                           {reg_rdata, lut_addr, wave_out, wave_is_sine, out_vx, out_ox, slot_vx, slot_ox});
      end
   endtask

   task automatic test_clear();
      int  n = 0;
      bit  early = 1'b0;
      run = 1'b1;
      reset_reg = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (slot_issue !== 1'b0) early = 1'b1;
         tick();
      end
      tests++;
      if (n != 32) begin fails++; $display("FAIL clear_len: got %0d want 32", n); end
      tests++;
      if (early) begin fails++; $display("FAIL clear_no_issue: got issue during clear want none"); end
      tests++;
      if ({slot_issue, slot_vx, slot_ox} !== 6'b100000) begin
         fails++; $display("FAIL first_issue: got %b want 100000", {slot_issue, slot_vx, slot_ox});
      end
      tick(); tick();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL pipe_latency: got out_valid %b want 0", out_valid); end
      tick();
      tests++;
      if ({out_valid, out_vx, out_ox, lut_addr, wave_is_sine, wave_out} !== {1'b1, 3'd0, 2'd0, 11'd8, 1'b1, 11'd0}) begin
         fails++; $display("FAIL slot0_visit1: got %h want %h",
                           {out_valid, out_vx, out_ox, lut_addr, wave_is_sine, wave_out},
                           {1'b1, 3'd0, 2'd0, 11'd8, 1'b1, 11'd0});
      end
   endtask

   task automatic test_phase();
      bit ok;
      wait_out(3'd0, 2'd0, ok);
      tests++;
      if (!ok || lut_addr !== 11'd16) begin fails++; $display("FAIL slot0_visit2: got %0d ok=%b want 16", lut_addr, ok); end
      wait_out(3'd0, 2'd0, ok);
      tests++;
      if (!ok || lut_addr !== 11'd24) begin fails++; $display("FAIL slot0_visit3: got %0d ok=%b want 24", lut_addr, ok); end
   endtask

   task automatic test_regs();
      bit ok;
      reg_wr(7'd6, 8'h10, 1'b1);
      reg_wr(7'd7, 8'h01, 1'b1);
      reg_wr(7'd22, 8'h33, 1'b0);
      reg_rd(7'd6);
      tests++;
      if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h10}) begin
         fails++; $display("FAIL rd_offs0: got %b/%h want 1/10", reg_rvalid, reg_rdata);
      end
      tick();
      tests++;
      if ({reg_rvalid, reg_rdata} !== {1'b0, 8'h10}) begin
         fails++; $display("FAIL rd_hold: got %b/%h want 0/10", reg_rvalid, reg_rdata);
      end
      reg_rd(7'd22);
      tests++;
      if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h00}) begin
         fails++; $display("FAIL wr_unselected: got %b/%h want 1/00", reg_rvalid, reg_rdata);
      end
      reg_rd(7'd7);
      tests++;
      if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h01}) begin
         fails++; $display("FAIL rd_mode0: got %b/%h want 1/01", reg_rvalid, reg_rdata);
      end
      reg_rd(7'h7F);
      tests++;
      if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h00}) begin
         fails++; $display("FAIL rd_unmapped: got %b/%h want 1/00", reg_rvalid, reg_rdata);
      end
      wait_out(3'd0, 2'd0, ok);
      tests++;
      if (!ok || {lut_addr, wave_is_sine, wave_out} !== {11'h0A0, 1'b0, 11'h4A0}) begin
         fails++; $display("FAIL saw_offset: got %h/%b/%h ok=%b want 0a0/0/4a0", lut_addr, wave_is_sine, wave_out, ok);
      end
      tick();
      tests++;
      if ({out_valid, out_vx, out_ox, lut_addr, wave_is_sine} !== {1'b1, 3'd0, 2'd1, 11'd32, 1'b1}) begin
         fails++; $display("FAIL ox1_untouched: got %h want %h",
                           {out_valid, out_vx, out_ox, lut_addr, wave_is_sine}, {1'b1, 3'd0, 2'd1, 11'd32, 1'b1});
      end
   endtask

   task automatic test_sync();
      bit ok, ok2;
      logic [10:0] exp_s [4];
      exp_s[0] = 11'd136; exp_s[1] = 11'd8; exp_s[2] = 11'd8; exp_s[3] = 11'd8;
      wait_issue(3'd5, 2'd0, ok);
      sync_req = 8'h04;
      tick();
      sync_req = 8'h00;
      wait_issue(3'd2, 2'd0, ok2);
      tick();
      sync_req = 8'h04;
      tick();
      sync_req = 8'h00;
      for (int o = 0; o < 4; o++) begin
         tick();
         tests++;
         if (!ok || !ok2 || {out_valid, out_vx, out_ox, lut_addr} !== {1'b1, 3'd2, 2'(o), exp_s[o]}) begin
            fails++; $display("FAIL sync_v1_ox%0d: got %h want %h", o,
                              {out_valid, out_vx, out_ox, lut_addr}, {1'b1, 3'd2, 2'(o), exp_s[o]});
         end
      end
      wait_out(3'd2, 2'd0, ok);
      tests++;
      if (!ok || lut_addr !== 11'd136) begin fails++; $display("FAIL sync_repend: got %0d ok=%b want 136", lut_addr, ok); end
      tick();
      tests++;
      if ({out_valid, out_vx, out_ox, lut_addr} !== {1'b1, 3'd2, 2'd1, 11'd16}) begin
         fails++; $display("FAIL sync_cleared: got %h want %h", {out_valid, out_vx, out_ox, lut_addr}, {1'b1, 3'd2, 2'd1, 11'd16});
      end
   endtask

   task automatic test_wrap();
      bit ok, ok2;
      logic [22:0] exp_w [8];
      exp_w[0] = {11'h400, 1'b0, 11'h000}; exp_w[1] = {11'h380, 1'b0, 11'h400};
      exp_w[2] = {11'h780, 1'b0, 11'h4FE}; exp_w[3] = {11'h780, 1'b1, 11'h000};
      exp_w[4] = {11'h380, 1'b0, 11'h780}; exp_w[5] = {11'h300, 1'b0, 11'h400};
      exp_w[6] = {11'h700, 1'b0, 11'h5FE}; exp_w[7] = {11'h700, 1'b1, 11'h000};
      reg_wr(7'd54, 8'h80, 1'b1);
      reg_wr(7'd38, 8'h80, 1'b1);
      reg_wr(7'd23, 8'h02, 1'b1);
      reg_wr(7'd39, 8'h03, 1'b1);
      osc_pitch_val = 24'hF00000;
      modulation = -11'sd1024;
      wait_issue(3'd7, 2'd0, ok);
      sync_req = 8'h08;
      tick();
      sync_req = 8'h00;
      for (int k = 0; k < 2; k++) begin
         wait_out(3'd3, 2'd0, ok2);
         for (int o = 0; o < 4; o++) begin
            if (o != 0) tick();
            tests++;
            if (!ok || !ok2 || out_ox !== 2'(o) || {lut_addr, wave_is_sine, wave_out} !== exp_w[k*4+o]) begin
               fails++; $display("FAIL wrap_v%0d_ox%0d: got %h ox=%0d want %h", k, o,
                                 {lut_addr, wave_is_sine, wave_out}, out_ox, exp_w[k*4+o]);
            end
         end
      end
   endtask

   task automatic test_drain_reset();
      int n = 0;
      bit ov_seen = 1'b0;
      run = 1'b0;
      tick();
      tests++;
      if ({slot_issue, out_valid} !== 2'b01) begin
         fails++; $display("FAIL drain1: got issue/valid %b want 01", {slot_issue, out_valid});
      end
      tick();
      tests++;
      if ({slot_issue, out_valid} !== 2'b01) begin
         fails++; $display("FAIL drain2: got issue/valid %b want 01", {slot_issue, out_valid});
      end
      tick();
      reset_reg = 1'b1;
      #1;
      tests++;
      if ({out_valid, lut_addr, wave_out, wave_is_sine, out_vx, out_ox, slot_issue} !== 30'd0) begin
         fails++; $display("FAIL abort_outputs: got %h want 0",
                           {out_valid, lut_addr, wave_out, wave_is_sine, out_vx, out_ox, slot_issue});
      end
      tests++;
      if ({busy, reg_rvalid, reg_rdata} !== {1'b1, 1'b0, 8'h00}) begin
         fails++; $display("FAIL abort_ctrl: got %b/%b/%h want 1/0/00", busy, reg_rvalid, reg_rdata);
      end
      tick(); tick();
      reset_reg = 1'b0;
      fork
         begin
            while (busy === 1'b1 && n < 100) begin
               n++;
               if (out_valid !== 1'b0 || slot_issue !== 1'b0) ov_seen = 1'b1;
               tick();
            end
         end
         begin
            reg_rd(7'd7);
            tests++;
            if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h00}) begin
               fails++; $display("FAIL clr_mode_reset: got %b/%h want 1/00", reg_rvalid, reg_rdata);
            end
            reg_wr(7'd54, 8'hA5, 1'b1);
            reg_rd(7'd54);
            tests++;
            if ({reg_rvalid, reg_rdata} !== {1'b1, 8'hA5}) begin
               fails++; $display("FAIL clr_rd_offs3: got %b/%h want 1/a5", reg_rvalid, reg_rdata);
            end
            reg_wr(7'd55, 8'hFF, 1'b1);
            reg_rd(7'd55);
            tests++;
            if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h03}) begin
               fails++; $display("FAIL clr_rd_mode3: got %b/%h want 1/03", reg_rvalid, reg_rdata);
            end
            reg_rd(7'd8);
            tests++;
            if ({reg_rvalid, reg_rdata} !== {1'b1, 8'h00}) begin
               fails++; $display("FAIL clr_rd_unmapped: got %b/%h want 1/00", reg_rvalid, reg_rdata);
            end
         end
      join
      tests++;
      if (n != 32) begin fails++; $display("FAIL reclear_len: got %0d want 32", n); end
      tests++;
      if (ov_seen) begin fails++; $display("FAIL reclear_quiet: got activity during clear want none"); end
      tick(); tick();
      tests++;
      if ({busy, slot_issue, out_valid, slot_vx, slot_ox} !== 8'd0) begin
         fails++; $display("FAIL idle_hold: got %b want 00000000", {busy, slot_issue, out_valid, slot_vx, slot_ox});
      end
   endtask

   initial begin
      reset_reg = 1'b1; run = 1'b0;
      osc_pitch_val = 24'h010000; modulation = '0; sync_req = '0;
      reg_write = 1'b0; reg_read = 1'b0; osc_sel = 1'b0; reg_adr = '0; reg_wdata = '0;
      repeat (3) tick();
      test_reset();
      test_clear();
      test_phase();
      test_regs();
      test_sync();
      test_wrap();
      test_drain_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
